// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Issues one word-aligned request per instruction over a req/gnt + rvalid
// handshake, holds the returned word for decode, and pulses pc_en when
// decode takes it. A flush abandons whatever fetch or buffered word is in
// flight. An outstanding response is always drained before the next
// request goes out. A misaligned pc or a missing response latches err
// until reset.
module fetch_unit #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rstd,
    input  logic [31:0]      pc,
    input  logic             flush,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ins,
    output logic             ins_valid,
    input  logic             ins_ready,
    output logic             pc_en,
    output logic             err,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_HOLD,
        S_ERR
    } state_t;

    localparam logic [7:0]       TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0]       TIMER_ONE  = 8'd1;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    logic [7:0] timer;
    logic       timed_out;

    // Response wait has run its full budget; >= keeps a flush at the last
    // WAIT cycle from pushing the timer past the limit in DRAIN.
    assign timed_out = (timer >= TIMER_LAST);

    // Writeback advances pc exactly on the edge where decode takes the word.
    assign pc_en = ins_valid & ins_ready & ~flush;

    // Fetch sequencer: request, await data, buffer it, hand it to decode.
    always_ff @(posedge clk) begin
        if (rstd) begin
            state       <= S_IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= 32'h0;
            ins         <= 32'h0;
            ins_valid   <= 1'b0;
            err         <= 1'b0;
            fetch_count <= '0;
            timer       <= 8'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pc[1:0] != 2'b00) begin
                        err   <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        imem_addr <= pc;
                        imem_req  <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A grant coinciding with flush still owes us a response.
                    if (imem_gnt) begin
                        imem_req <= 1'b0;
                        timer    <= 8'h0;
                        state    <= flush ? S_DRAIN : S_WAIT;
                    end else if (flush) begin
                        imem_req <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (flush) begin
                            state <= S_IDLE;
                        end else begin
                            ins         <= imem_rdata;
                            ins_valid   <= 1'b1;
                            fetch_count <= fetch_count + CNT_ONE;
                            state       <= S_HOLD;
                        end
                    end else if (timed_out) begin
                        err   <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        timer <= timer + TIMER_ONE;
                        if (flush) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) begin
                        state <= S_IDLE;
                    end else if (timed_out) begin
                        err   <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        timer <= timer + TIMER_ONE;
                    end
                end
                S_HOLD: begin
                    if (flush || ins_ready) begin
                        ins_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                S_ERR: begin
                    imem_req  <= 1'b0;
                    ins_valid <= 1'b0;
                    err       <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
